pic_exec_seq: RTL and testbench
===============================

PIC_EXEC_SEQ -- requirements
Module: pic_exec_seq

Interface
REQ-001 SHALL have port clk2, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port inst, input, 12 bits: PIC16C5x-format instruction word.
REQ-004 SHALL have ports inst_valid (input, 1) and inst_ready (output, 1): instruction handshake; transfer when both are high on a clk2 edge.
REQ-005 SHALL have port alu_zero, input, 1 bit: zero flag of the current ALU result.
REQ-006 SHALL have outputs fsel (5), alua_sel (2), alub_sel (2), b_mux (3), bdpol (1), k (8): datapath mux controls.
REQ-007 SHALL have outputs alu_op (4), w_we (1), f_we (1): ALU operation, W write strobe, file write strobe.
REQ-008 SHALL have outputs skipped (1) and illegal (1): one-cycle status pulses.

Function
REQ-009 SHALL implement an FSM with states IDLE, DECODE, EXEC and SKIP.
REQ-010 SHALL assert inst_ready only in IDLE and SKIP, and only while resetn is high.
REQ-011 SHALL, in IDLE on handshake, register inst and go to DECODE; with no handshake, stay in IDLE.
REQ-012 SHALL, in DECODE, drive fsel=inst[4:0], b_mux=inst[7:5], k=inst[7:0] and the decoded alua_sel/alub_sel/bdpol, then go to EXEC.
REQ-013 SHALL hold every mux control stable from DECODE through EXEC; the datapath registers its operands at the DECODE-to-EXEC edge.
REQ-014 SHALL, in EXEC, drive alu_op, pulse w_we or f_we for exactly one cycle, and sample alu_zero.
REQ-015 SHALL leave EXEC for SKIP when the skip condition holds, otherwise for IDLE; latency is 3 cycles per instruction.
REQ-016 SHALL decode as follows (A/B selects: 00=W, 01=file, 10=literal, 11=bit-mask on A / constant 1 on B):
 - ADDWF/ANDWF/IORWF/XORWF: A=W, B=file, op ADD/AND/IOR/XOR; destination d=inst[5]: 0 writes W, 1 writes file.
 - SUBWF: A=file, B=W, op SUB (A-B); destination d.
 - INCF/DECF/DECFSZ: A=file, B=1, op ADD/SUB; destination d; DECFSZ skips when alu_zero=1.
 - MOVF: A=file, op PASSA, destination d.
 - COMF: A=file, op COM, destination d.
 - MOVWF: A=W, op PASSA, f_we.
 - CLRF: op CLR, f_we.
 - CLRW: op CLR, w_we.
 - BCF: A=mask, bdpol=1, B=file, op AND, f_we.
 - BSF: A=mask, bdpol=0, B=file, op IOR, f_we.
 - BTFSC/BTFSS: A=mask, bdpol=0, B=file, op AND, no write; BTFSC skips when alu_zero=1, BTFSS skips when alu_zero=0.
 - MOVLW: B=literal, op PASSB, w_we.
 - IORLW/ANDLW/XORLW: A=W, B=literal, op IOR/AND/XOR, w_we.
 - NOP: no write.
REQ-017 SHALL treat every other opcode as NOP and pulse illegal in EXEC.
REQ-018 SHALL, in SKIP, accept exactly one instruction, discard it, pulse skipped in that handshake cycle, and return to IDLE; without inst_valid it SHALL wait in SKIP.
REQ-019 SHALL keep w_we, f_we, skipped and illegal low in every state other than the one given above.

Reset
REQ-020 SHALL, when resetn is sampled low, enter IDLE, discard any in-flight or pending-skip instruction, and clear all registered outputs to 0.
REQ-021 SHALL take effect regardless of the current state, including a reset asserted during EXEC.

Structure
REQ-022 SHALL take the alu_op codes (ADD, SUB, AND, IOR, XOR, PASSA, PASSB, COM, CLR), the mux-select constants and the state encoding from a shared package, pic_pkg.
REQ-023 SHALL place decode in one combinational sub-module, pic_decode, mapping inst[11:0] to selects, op, write enables, skip type and illegal.

Verification
REQ-024 SHALL test: reset, then MOVLW 0xC5A -> w_we pulses in cycle 3, alub_sel=10, k=0x5A, alu_op=PASSB.
REQ-025 SHALL test: ADDWF 0x1E7 (d=1, f=7) -> fsel=07, alua_sel=00, alub_sel=01, f_we only.
REQ-026 SHALL test: BTFSS 0x7A3 with alu_zero=0 -> SKIP; the next instruction is consumed, skipped=1, no write strobes.
REQ-027 SHALL test: DECFSZ 0x2E4 with alu_zero=1 -> f_we=1 and SKIP; with alu_zero=0 -> return to IDLE.
REQ-028 SHALL test: illegal word 0x003 -> illegal pulse, no write strobes; resetn low during EXEC -> IDLE next cycle with no strobe.
REQ-029 SHALL test: inst_valid held high continuously -> inst_ready high once per 3 cycles only.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared constants for the PIC16C5x execution sequencer: ALU op codes,
// datapath mux selects, skip kinds and FSM state encoding.
package pic_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_IOR   = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_PASSA = 4'd5,
    ALU_PASSB = 4'd6,
    ALU_COM   = 4'd7,
    ALU_CLR   = 4'd8
  } alu_op_e;

  // Code 2'b11 means bit-mask on the A side and constant 1 on the B side.
  localparam logic [1:0] SEL_W    = 2'b00;
  localparam logic [1:0] SEL_FILE = 2'b01;
  localparam logic [1:0] SEL_LIT  = 2'b10;
  localparam logic [1:0] SEL_MASK = 2'b11;
  localparam logic [1:0] SEL_ONE  = 2'b11;

  typedef enum logic [1:0] {
    SKIP_NONE = 2'd0,
    SKIP_ZERO = 2'd1,
    SKIP_NZ   = 2'd2
  } skip_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_SKIP   = 2'd3
  } state_e;

endpackage

// File: rtl/pic_decode.sv
// Combinational PIC16C5x instruction decoder: maps a 12-bit instruction word
// to ALU operand selects, op, write strobes, skip kind and illegal flag.
module pic_decode
  import pic_pkg::*;
(
  input  logic [11:0] inst,
  output logic [1:0]  alua_sel,
  output logic [1:0]  alub_sel,
  output logic        bdpol,
  output alu_op_e     alu_op,
  output logic        w_we,
  output logic        f_we,
  output skip_e       skip_type,
  output logic        illegal
);

  logic d;
  assign d = inst[5];

  always_comb begin
    alua_sel  = SEL_W;
    alub_sel  = SEL_W;
    bdpol     = 1'b0;
    alu_op    = ALU_ADD;
    w_we      = 1'b0;
    f_we      = 1'b0;
    skip_type = SKIP_NONE;
    illegal   = 1'b0;
    casez (inst)
      12'b0000_0000_0000: ;
      12'b0000_001?_????: begin alua_sel = SEL_W; alu_op = ALU_PASSA; f_we = 1'b1; end
      12'b0000_0100_0000: begin alu_op = ALU_CLR; w_we = 1'b1; end
      12'b0000_011?_????: begin alu_op = ALU_CLR; f_we = 1'b1; end
      12'b0000_10??_????: begin
        alua_sel = SEL_FILE; alub_sel = SEL_W; alu_op = ALU_SUB;
        w_we = ~d; f_we = d;
      end
      12'b0000_11??_????: begin
        alua_sel = SEL_FILE; alub_sel = SEL_ONE; alu_op = ALU_SUB;
        w_we = ~d; f_we = d;
      end
      12'b0001_????_????: begin
        alua_sel = SEL_W; alub_sel = SEL_FILE; w_we = ~d; f_we = d;
        case (inst[7:6])
          2'b00:   alu_op = ALU_IOR;
          2'b01:   alu_op = ALU_AND;
          2'b10:   alu_op = ALU_XOR;
          default: alu_op = ALU_ADD;
        endcase
      end
      12'b0010_00??_????: begin alua_sel = SEL_FILE; alu_op = ALU_PASSA; w_we = ~d; f_we = d; end
      12'b0010_01??_????: begin alua_sel = SEL_FILE; alu_op = ALU_COM; w_we = ~d; f_we = d; end
      12'b0010_10??_????: begin
        alua_sel = SEL_FILE; alub_sel = SEL_ONE; alu_op = ALU_ADD;
        w_we = ~d; f_we = d;
      end
      12'b0010_11??_????: begin
        alua_sel = SEL_FILE; alub_sel = SEL_ONE; alu_op = ALU_SUB;
        w_we = ~d; f_we = d; skip_type = SKIP_ZERO;
      end
      // Bit ops: the datapath builds the mask from b_mux, inverted when bdpol=1.
      12'b0100_????_????: begin
        alua_sel = SEL_MASK; bdpol = 1'b1; alub_sel = SEL_FILE; alu_op = ALU_AND; f_we = 1'b1;
      end
      12'b0101_????_????: begin
        alua_sel = SEL_MASK; alub_sel = SEL_FILE; alu_op = ALU_IOR; f_we = 1'b1;
      end
      12'b0110_????_????: begin
        alua_sel = SEL_MASK; alub_sel = SEL_FILE; alu_op = ALU_AND; skip_type = SKIP_ZERO;
      end
      12'b0111_????_????: begin
        alua_sel = SEL_MASK; alub_sel = SEL_FILE; alu_op = ALU_AND; skip_type = SKIP_NZ;
      end
      12'b1100_????_????: begin alub_sel = SEL_LIT; alu_op = ALU_PASSB; w_we = 1'b1; end
      12'b1101_????_????: begin alua_sel = SEL_W; alub_sel = SEL_LIT; alu_op = ALU_IOR; w_we = 1'b1; end
      12'b1110_????_????: begin alua_sel = SEL_W; alub_sel = SEL_LIT; alu_op = ALU_AND; w_we = 1'b1; end
      12'b1111_????_????: begin alua_sel = SEL_W; alub_sel = SEL_LIT; alu_op = ALU_XOR; w_we = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pic_exec_seq.sv
// Three-cycle instruction sequencer (IDLE -> DECODE -> EXEC) with a SKIP state
// that swallows the instruction following a taken conditional skip.
module pic_exec_seq
  import pic_pkg::*;
(
  input  logic        clk2,
  input  logic        resetn,
  input  logic [11:0] inst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic        alu_zero,
  output logic [4:0]  fsel,
  output logic [1:0]  alua_sel,
  output logic [1:0]  alub_sel,
  output logic [2:0]  b_mux,
  output logic        bdpol,
  output logic [7:0]  k,
  output logic [3:0]  alu_op,
  output logic        w_we,
  output logic        f_we,
  output logic        skipped,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [11:0] inst_q;

  logic [1:0]  dec_alua, dec_alub;
  logic        dec_bdpol, dec_w_we, dec_f_we, dec_illegal;
  alu_op_e     dec_op;
  skip_e       dec_skip;
  logic        skip_taken;

  pic_decode u_decode (
    .inst      (inst_q),
    .alua_sel  (dec_alua),
    .alub_sel  (dec_alub),
    .bdpol     (dec_bdpol),
    .alu_op    (dec_op),
    .w_we      (dec_w_we),
    .f_we      (dec_f_we),
    .skip_type (dec_skip),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk2) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && inst_valid) inst_q <= inst;
    end
  end

  assign skip_taken = (dec_skip == SKIP_ZERO && alu_zero) ||
                      (dec_skip == SKIP_NZ   && !alu_zero);

  // Pulses are gated by resetn so a reset landing in EXEC never leaks a write.
  always_comb begin
    state_d    = state_q;
    inst_ready = 1'b0;
    fsel       = '0;
    alua_sel   = '0;
    alub_sel   = '0;
    b_mux      = '0;
    bdpol      = 1'b0;
    k          = '0;
    alu_op     = '0;
    w_we       = 1'b0;
    f_we       = 1'b0;
    skipped    = 1'b0;
    illegal    = 1'b0;
    if (state_q == ST_DECODE || state_q == ST_EXEC) begin
      fsel     = inst_q[4:0];
      b_mux    = inst_q[7:5];
      k        = inst_q[7:0];
      alua_sel = dec_alua;
      alub_sel = dec_alub;
      bdpol    = dec_bdpol;
    end
    case (state_q)
      ST_IDLE: begin
        inst_ready = resetn;
        if (inst_valid) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        alu_op  = dec_op;
        w_we    = dec_w_we & resetn;
        f_we    = dec_f_we & resetn;
        illegal = dec_illegal & resetn;
        state_d = skip_taken ? ST_SKIP : ST_IDLE;
      end
      ST_SKIP: begin
        inst_ready = resetn;
        skipped    = inst_valid & resetn;
        if (inst_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pic_exec_seq.sv
// Directed self-checking bench for pic_exec_seq with hand-computed expectations.
module tb_pic_exec_seq;
  import pic_pkg::*;

  logic        clk2, resetn, inst_valid, inst_ready, alu_zero;
  logic [11:0] inst;
  logic [4:0]  fsel;
  logic [1:0]  alua_sel, alub_sel;
  logic [2:0]  b_mux;
  logic        bdpol;
  logic [7:0]  k;
  logic [3:0]  alu_op;
  logic        w_we, f_we, skipped, illegal;

  int n_checks = 0;
  int n_fails  = 0;

  pic_exec_seq dut (
    .clk2       (clk2),
    .resetn     (resetn),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .alu_zero   (alu_zero),
    .fsel       (fsel),
    .alua_sel   (alua_sel),
    .alub_sel   (alub_sel),
    .b_mux      (b_mux),
    .bdpol      (bdpol),
    .k          (k),
    .alu_op     (alu_op),
    .w_we       (w_we),
    .f_we       (f_we),
    .skipped    (skipped),
    .illegal    (illegal)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  task automatic tick();
    @(posedge clk2);
    #2;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    resetn = 1'b0; inst_valid = 1'b0; inst = '0; alu_zero = 1'b0;
    tick(); tick();
    check("rst_ready", inst_ready, 0);
    check("rst_wwe", w_we, 0);
    check("rst_fwe", f_we, 0);
    check("rst_fsel", fsel, 0);
    check("rst_skipped", skipped, 0);
    check("rst_illegal", illegal, 0);
    resetn = 1'b1; #1;
    check("idle_ready", inst_ready, 1);

    // MOVLW 0x5A
    inst = 12'hC5A; inst_valid = 1'b1;
    tick(); inst_valid = 1'b0; #1;
    check("movlw_dec_ready", inst_ready, 0);
    check("movlw_dec_alub", alub_sel, 2'b10);
    check("movlw_dec_k", k, 8'h5A);
    check("movlw_dec_wwe", w_we, 0);
    tick();
    check("movlw_ex_wwe", w_we, 1);
    check("movlw_ex_fwe", f_we, 0);
    check("movlw_ex_op", alu_op, ALU_PASSB);
    check("movlw_ex_alub", alub_sel, 2'b10);
    check("movlw_ex_k", k, 8'h5A);
    tick();
    check("movlw_done_wwe", w_we, 0);
    check("movlw_done_ready", inst_ready, 1);

    // ADDWF f=7, d=1
    inst = 12'h1E7; inst_valid = 1'b1;
    tick(); inst_valid = 1'b0; #1;
    check("addwf_fsel", fsel, 5'h07);
    check("addwf_alua", alua_sel, 2'b00);
    check("addwf_alub", alub_sel, 2'b01);
    check("addwf_bmux", b_mux, 3'd7);
    tick();
    check("addwf_fwe", f_we, 1);
    check("addwf_wwe", w_we, 0);
    check("addwf_op", alu_op, ALU_ADD);
    check("addwf_fsel_ex", fsel, 5'h07);
    tick();
    check("addwf_done_fwe", f_we, 0);

    // BTFSS f=3, b=5 with a nonzero result -> skip
    alu_zero = 1'b0;
    inst = 12'h7A3; inst_valid = 1'b1;
    tick(); inst_valid = 1'b0; #1;
    check("btfss_alua", alua_sel, 2'b11);
    check("btfss_alub", alub_sel, 2'b01);
    check("btfss_bdpol", bdpol, 0);
    check("btfss_bmux", b_mux, 3'd5);
    check("btfss_fsel", fsel, 5'h03);
    tick();
    check("btfss_op", alu_op, ALU_AND);
    check("btfss_wwe", w_we, 0);
    check("btfss_fwe", f_we, 0);
    tick();
    check("skip_wait_ready", inst_ready, 1);
    check("skip_wait_skipped", skipped, 0);
    tick();
    check("skip_hold_ready", inst_ready, 1);
    inst = 12'hC11; inst_valid = 1'b1; #1;
    check("skip_pulse", skipped, 1);
    check("skip_wwe", w_we, 0);
    check("skip_fwe", f_we, 0);
    tick(); inst_valid = 1'b0; #1;
    check("skip_after_pulse", skipped, 0);
    check("skip_after_ready", inst_ready, 1);
    check("skip_after_k", k, 0);
    tick();
    check("skip_discard_wwe", w_we, 0);
    check("skip_discard_ready", inst_ready, 1);

    // DECFSZ f=4, d=1, zero result -> write and skip
    alu_zero = 1'b1;
    inst = 12'h2E4; inst_valid = 1'b1;
    tick(); inst_valid = 1'b0; #1;
    check("decfsz_alua", alua_sel, 2'b01);
    check("decfsz_alub", alub_sel, 2'b11);
    tick();
    check("decfsz_fwe", f_we, 1);
    check("decfsz_wwe", w_we, 0);
    check("decfsz_op", alu_op, ALU_SUB);
    tick();
    inst = 12'h000; inst_valid = 1'b1; #1;
    check("decfsz_z_skipped", skipped, 1);
    tick(); inst_valid = 1'b0; #1;
    check("decfsz_z_back_idle", inst_ready, 1);

    // DECFSZ with nonzero result -> straight back to IDLE
    alu_zero = 1'b0;
    inst = 12'h2E4; inst_valid = 1'b1;
    tick(); inst_valid = 1'b0; #1;
    tick();
    check("decfsz_nz_fwe", f_we, 1);
    tick();
    inst = 12'h000; inst_valid = 1'b1; #1;
    check("decfsz_nz_skipped", skipped, 0);
    check("decfsz_nz_ready", inst_ready, 1);
    tick(); inst_valid = 1'b0; #1;
    check("decfsz_nz_next_decode", inst_ready, 0);
    tick();
    check("nop_wwe", w_we, 0);
    check("nop_fwe", f_we, 0);
    check("nop_illegal", illegal, 0);
    tick();

    // Illegal word (SLEEP)
    inst = 12'h003; inst_valid = 1'b1;
    tick(); inst_valid = 1'b0; #1;
    tick();
    check("illegal_pulse", illegal, 1);
    check("illegal_wwe", w_we, 0);
    check("illegal_fwe", f_we, 0);
    tick();
    check("illegal_done", illegal, 0);

    // Reset asserted while MOVLW is in EXEC
    inst = 12'hC33; inst_valid = 1'b1;
    tick(); inst_valid = 1'b0; #1;
    tick();
    resetn = 1'b0; #1;
    check("rst_exec_wwe", w_we, 0);
    check("rst_exec_ready", inst_ready, 0);
    tick();
    resetn = 1'b1; #1;
    check("rst_exec_idle_ready", inst_ready, 1);
    check("rst_exec_idle_wwe", w_we, 0);
    check("rst_exec_idle_k", k, 0);

    // Reset drops a pending skip
    alu_zero = 1'b0;
    inst = 12'h7A3; inst_valid = 1'b1;
    tick(); inst_valid = 1'b0; #1;
    tick(); tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    inst = 12'hC44; inst_valid = 1'b1; #1;
    check("rst_skip_no_pulse", skipped, 0);
    tick(); #1;
    check("rst_skip_accepted", inst_ready, 0);
    check("rst_skip_k", k, 8'h44);

    // Continuous inst_valid: one acceptance every three cycles
    tick(); tick();
    inst = 12'hC01; inst_valid = 1'b1; #1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("stream_ready_%0d", i), inst_ready, (i % 3 == 0) ? 16'd1 : 16'd0);
      check($sformatf("stream_wwe_%0d", i), w_we, (i % 3 == 2) ? 16'd1 : 16'd0);
      tick();
    end
    inst_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
